// File: rtl/adc_frame_averager.sv
// adc_frame_averager
// Block-averages 2^LOG2_N consecutive sample pairs from the dual-channel ADC
// controller with round-half-up rounding. One averaged pair per block is held
// in a single-entry valid/ready output slot. A finished block that finds the
// slot still occupied is dropped and raises a sticky overrun flag.
module adc_frame_averager #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned LOG2_N = 3
) (
    input  logic              clk_20M,
    input  logic              reset,
    input  logic [DATA_W-1:0] pdata1,
    input  logic [DATA_W-1:0] pdata2,
    input  logic              new_Data,
    input  logic              clear,
    output logic [DATA_W-1:0] avg1,
    output logic [DATA_W-1:0] avg2,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic              overrun,
    output logic [LOG2_N-1:0] sample_cnt
);

    localparam int unsigned ACC_W = DATA_W + LOG2_N;
    localparam int unsigned SUM_W = ACC_W + 1;

    localparam logic [SUM_W-1:0] HALF    = SUM_W'(1) << (LOG2_N - 1);
    localparam logic [SUM_W-1:0] MAX_RES = {{(SUM_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

    logic              nd_q,      nd_d;
    logic [ACC_W-1:0]  acc1_q,    acc1_d;
    logic [ACC_W-1:0]  acc2_q,    acc2_d;
    logic [LOG2_N-1:0] cnt_q,     cnt_d;
    logic [DATA_W-1:0] avg1_q,    avg1_d;
    logic [DATA_W-1:0] avg2_q,    avg2_d;
    logic              valid_q,   valid_d;
    logic              overrun_q, overrun_d;

    logic              accept;
    logic              xfer;
    logic              last_sample;
    logic [SUM_W-1:0]  sum1, sum2;
    logic [SUM_W-1:0]  rnd1, rnd2;
    logic [DATA_W-1:0] res1, res2;

    // Block sums including the current sample, rounded and saturated
    always_comb begin
        sum1 = {1'b0, acc1_q} + {{(SUM_W-DATA_W){1'b0}}, pdata1};
        sum2 = {1'b0, acc2_q} + {{(SUM_W-DATA_W){1'b0}}, pdata2};
        rnd1 = (sum1 + HALF) >> LOG2_N;
        rnd2 = (sum2 + HALF) >> LOG2_N;
        res1 = (rnd1 > MAX_RES) ? '1 : rnd1[DATA_W-1:0];
        res2 = (rnd2 > MAX_RES) ? '1 : rnd2[DATA_W-1:0];
    end

    // Next-state: edge-detected accept, accumulation, output slot and overrun
    always_comb begin
        nd_d      = new_Data;
        acc1_d    = acc1_q;
        acc2_d    = acc2_q;
        cnt_d     = cnt_q;
        avg1_d    = avg1_q;
        avg2_d    = avg2_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        accept      = new_Data & ~nd_q;
        xfer        = valid_q & avg_ready;
        last_sample = (cnt_q == '1);

        if (xfer) begin
            valid_d = 1'b0;
        end

        if (clear) begin
            acc1_d    = '0;
            acc2_d    = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else if (accept) begin
            if (last_sample) begin
                acc1_d = '0;
                acc2_d = '0;
                cnt_d  = '0;
                // Slot is free if empty or being emptied this very cycle
                if (!valid_q || xfer) begin
                    avg1_d  = res1;
                    avg2_d  = res2;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                acc1_d = acc1_q + {{LOG2_N{1'b0}}, pdata1};
                acc2_d = acc2_q + {{LOG2_N{1'b0}}, pdata2};
                cnt_d  = cnt_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_20M or posedge reset) begin
        if (reset) begin
            nd_q      <= 1'b0;
            acc1_q    <= '0;
            acc2_q    <= '0;
            cnt_q     <= '0;
            avg1_q    <= '0;
            avg2_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            nd_q      <= nd_d;
            acc1_q    <= acc1_d;
            acc2_q    <= acc2_d;
            cnt_q     <= cnt_d;
            avg1_q    <= avg1_d;
            avg2_q    <= avg2_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign avg1       = avg1_q;
    assign avg2       = avg2_q;
    assign avg_valid  = valid_q;
    assign overrun    = overrun_q;
    assign sample_cnt = cnt_q;

endmodule
